control_estados: RTL and testbench

//  Registered controller FSM that produces the 2-bit state code consumed by the seven-segment state decoder.

---
 rtl/estados_pkg.sv | 20 ++
 rtl/control_estados_antirrebote.sv | 46 ++++
 rtl/control_estados.sv | 143 ++++++++++++++
 tb/tb_control_estados.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/estados_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : estados_pkg
//  Purpose  : State encoding shared by the controller FSM and the
//             seven-segment state decoder, so both sides agree on one code.
//  Revision : 1.0 - initial release
// ============================================================================
package estados_pkg;

    localparam int c_EST_W = 2;

    typedef enum logic [c_EST_W-1:0] {
        ST_IDLE   = 2'b00,
        ST_ALERT  = 2'b01,
        ST_ACTIVE = 2'b10,
        ST_FAULT  = 2'b11
    } estado_t;

endpackage : estados_pkg
`default_nettype wire

// File: rtl/control_estados_antirrebote.sv
`default_nettype none
// ============================================================================
//  Module   : antirrebote
//  Purpose  : Level debouncer. The output follows the input only after
//             DEB_CYCLES consecutive samples that differ from the current
//             output; any shorter excursion is discarded.
//             Only compiled when DEBOUNCE_EN is defined, since the
//             controller has no other user for it.
//  Revision : 1.0 - initial release
// ============================================================================
`ifdef DEBOUNCE_EN
module antirrebote #(
    parameter int DEB_CYCLES = 8,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_dout;

    // Count consecutive samples disagreeing with the output; commit on the last one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_dout <= 1'b0;
        end else if (din == r_dout) begin
            r_cnt  <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt  <= '0;
            r_dout <= din;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign dout = r_dout;

endmodule : antirrebote
`endif
`default_nettype wire

// File: rtl/control_estados.sv
`default_nettype none
// ============================================================================
//  Module   : control_estados
//  Purpose  : Registered controller FSM producing the 2-bit state code for
//             the seven-segment decoder. Synchronises sensor/fault/ack,
//             times the ALERT dwell and ACTIVE minimum-on phase, and drives
//             actuator, alarm and a one-cycle state-change pulse.
//  Config   : DEBOUNCE_EN - when defined, sensor and ack are debounced
//             (antirrebote) after synchronisation; fault_in never is.
//  Revision : 1.0 - initial release
// ============================================================================
module control_estados
    import estados_pkg::*;
#(
    parameter int ALERT_CYCLES  = 16,
    parameter int MIN_ON_CYCLES = 32,
    parameter int DEB_CYCLES    = 8,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sensor,
    input  logic       fault_in,
    input  logic       ack,
    output logic [1:0] Estados,
    output logic       actuador,
    output logic       alarma,
    output logic       cambio
);

    localparam logic [CNT_W-1:0] c_ALERT_LAST  = CNT_W'(ALERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_MIN_ON_LAST = CNT_W'(MIN_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_TIMER_MAX   = '1;

    // Bit order of the synchroniser vectors: {ack, fault_in, sensor}
    logic [2:0]       r_sync_meta;
    logic [2:0]       r_sync_q;
    logic             w_s_q;
    logic             w_f_q;
    logic             w_a_q;

    estado_t          r_state;
    estado_t          w_next;
    logic [CNT_W-1:0] r_timer;
    logic             r_actuador;
    logic             r_alarma;
    logic             r_cambio;

    // Two-flop synchronisers for the three asynchronous inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_meta <= '0;
            r_sync_q    <= '0;
        end else begin
            r_sync_meta <= {ack, fault_in, sensor};
            r_sync_q    <= r_sync_meta;
        end
    end

    // Fault must react as fast as possible, so it is never debounced.
    assign w_f_q = r_sync_q[1];

`ifdef DEBOUNCE_EN
    antirrebote #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_deb_sensor (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (r_sync_q[0]),
        .dout    (w_s_q)
    );

    antirrebote #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_deb_ack (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (r_sync_q[2]),
        .dout    (w_a_q)
    );
`else
    assign w_s_q = r_sync_q[0];
    assign w_a_q = r_sync_q[2];
`endif

    // Next-state selection; a synchronised fault overrides every other condition.
    always_comb begin
        w_next = r_state;
        if (w_f_q) begin
            w_next = ST_FAULT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_s_q) w_next = ST_ALERT;
                end
                ST_ALERT: begin
                    if (!w_s_q)                       w_next = ST_IDLE;
                    else if (r_timer == c_ALERT_LAST) w_next = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    // Sensor dropping early is held off until the minimum-on time elapses
                    if (!w_s_q && (r_timer >= c_MIN_ON_LAST)) w_next = ST_IDLE;
                end
                ST_FAULT: begin
                    // Reaching here implies the fault is already clear
                    if (w_a_q) w_next = ST_IDLE;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // State register, phase timer and registered outputs, all updated on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_actuador <= 1'b0;
            r_alarma   <= 1'b0;
            r_cambio   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_actuador <= (w_next == ST_ACTIVE);
            r_alarma   <= (w_next == ST_FAULT);
            r_cambio   <= (w_next != r_state);
            if (w_next != r_state) begin
                r_timer <= '0;
            end else if (((r_state == ST_ALERT) || (r_state == ST_ACTIVE)) &&
                         (r_timer != c_TIMER_MAX)) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    assign Estados  = r_state;
    assign actuador = r_actuador;
    assign alarma   = r_alarma;
    assign cambio   = r_cambio;

endmodule : control_estados
`default_nettype wire

// File: tb/tb_control_estados.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_estados
//  Purpose  : Directed self-checking bench for control_estados with
//             ALERT_CYCLES=4, MIN_ON_CYCLES=6, DEB_CYCLES=8.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_control_estados;

    localparam int c_ALERT  = 4;
    localparam int c_MIN_ON = 6;
    localparam int c_DEB    = 8;
    localparam int c_CNT_W  = 8;

    logic       clk;
    logic       reset_n;
    logic       sensor;
    logic       fault_in;
    logic       ack;
    logic [1:0] Estados;
    logic       actuador;
    logic       alarma;
    logic       cambio;

    int n_chk;
    int n_fail;

    control_estados #(
        .ALERT_CYCLES  (c_ALERT),
        .MIN_ON_CYCLES (c_MIN_ON),
        .DEB_CYCLES    (c_DEB),
        .CNT_W         (c_CNT_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sensor   (sensor),
        .fault_in (fault_in),
        .ack      (ack),
        .Estados  (Estados),
        .actuador (actuador),
        .alarma   (alarma),
        .cambio   (cambio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; sensor = 1'b0; fault_in = 1'b0; ack = 1'b0;
        tick(2);
        n_chk++; if (Estados !== 2'b00) begin n_fail++; $display("FAIL reset_estados: got %b expected 00", Estados); end
        n_chk++; if (actuador !== 1'b0) begin n_fail++; $display("FAIL reset_actuador: got %b expected 0", actuador); end
        n_chk++; if (alarma !== 1'b0)   begin n_fail++; $display("FAIL reset_alarma: got %b expected 0", alarma); end
        n_chk++; if (cambio !== 1'b0)   begin n_fail++; $display("FAIL reset_cambio: got %b expected 0", cambio); end
        reset_n = 1'b1;
        tick(3);
        n_chk++; if (Estados !== 2'b00) begin n_fail++; $display("FAIL idle_hold: got %b expected 00", Estados); end
    endtask

    // Sensor rises: ALERT after 3 clocks, ACTIVE exactly c_ALERT clocks later.
    task automatic test_alert_active();
        sensor = 1'b1;
        tick(2);
        n_chk++; if (Estados !== 2'b00) begin n_fail++; $display("FAIL alert_early: got %b expected 00", Estados); end
        tick(1);
        n_chk++; if (Estados !== 2'b01 || cambio !== 1'b1) begin n_fail++; $display("FAIL alert_entry: got %b/%b expected 01/1", Estados, cambio); end
        tick(1);
        n_chk++; if (Estados !== 2'b01 || cambio !== 1'b0) begin n_fail++; $display("FAIL alert_pulse_end: got %b/%b expected 01/0", Estados, cambio); end
        tick(2);
        n_chk++; if (Estados !== 2'b01 || actuador !== 1'b0) begin n_fail++; $display("FAIL alert_dwell: got %b/%b expected 01/0", Estados, actuador); end
        tick(1);
        n_chk++; if (Estados !== 2'b10 || actuador !== 1'b1 || cambio !== 1'b1) begin n_fail++; $display("FAIL active_entry: got %b/%b/%b expected 10/1/1", Estados, actuador, cambio); end
        tick(1);
        n_chk++; if (Estados !== 2'b10 || cambio !== 1'b0) begin n_fail++; $display("FAIL active_hold: got %b/%b expected 10/0", Estados, cambio); end
    endtask

    // Entered from test_alert_active one clock after ACTIVE entry.
    task automatic test_min_on();
        tick(1);
        sensor = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            tick(1);
            n_chk++; if (Estados !== 2'b10 || actuador !== 1'b1) begin n_fail++; $display("FAIL min_on_k%0d: got %b/%b expected 10/1", k, Estados, actuador); end
        end
        tick(1);
        n_chk++; if (Estados !== 2'b00 || actuador !== 1'b0 || cambio !== 1'b1) begin n_fail++; $display("FAIL min_on_exit: got %b/%b/%b expected 00/0/1", Estados, actuador, cambio); end
        tick(1);
        n_chk++; if (Estados !== 2'b00 || cambio !== 1'b0) begin n_fail++; $display("FAIL min_on_after: got %b/%b expected 00/0", Estados, cambio); end
    endtask

    // Two-clock sensor pulse: brief ALERT, abort to IDLE, actuator never set.
    task automatic test_abort();
        sensor = 1'b1;
        tick(2);
        sensor = 1'b0;
        tick(1);
        n_chk++; if (Estados !== 2'b01 || actuador !== 1'b0) begin n_fail++; $display("FAIL abort_alert: got %b/%b expected 01/0", Estados, actuador); end
        tick(1);
        n_chk++; if (Estados !== 2'b01 || actuador !== 1'b0) begin n_fail++; $display("FAIL abort_alert2: got %b/%b expected 01/0", Estados, actuador); end
        tick(1);
        n_chk++; if (Estados !== 2'b00 || actuador !== 1'b0 || cambio !== 1'b1) begin n_fail++; $display("FAIL abort_exit: got %b/%b/%b expected 00/0/1", Estados, actuador, cambio); end
        tick(2);
        n_chk++; if (Estados !== 2'b00 || cambio !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %b/%b expected 00/0", Estados, cambio); end
    endtask

    // Fault lands on the ALERT expiry edge and must win; ack only honoured once fault clears.
    task automatic test_fault();
        sensor = 1'b1;
        tick(3);
        n_chk++; if (Estados !== 2'b01) begin n_fail++; $display("FAIL fault_pre_alert: got %b expected 01", Estados); end
        tick(1);
        fault_in = 1'b1;
        tick(2);
        n_chk++; if (Estados !== 2'b01 || alarma !== 1'b0) begin n_fail++; $display("FAIL fault_pre: got %b/%b expected 01/0", Estados, alarma); end
        tick(1);
        n_chk++; if (Estados !== 2'b11 || alarma !== 1'b1 || actuador !== 1'b0 || cambio !== 1'b1) begin n_fail++; $display("FAIL fault_entry: got %b/%b/%b/%b expected 11/1/0/1", Estados, alarma, actuador, cambio); end
        ack = 1'b1; sensor = 1'b0;
        tick(4);
        n_chk++; if (Estados !== 2'b11 || alarma !== 1'b1 || cambio !== 1'b0) begin n_fail++; $display("FAIL fault_ack_ignored: got %b/%b/%b expected 11/1/0", Estados, alarma, cambio); end
        fault_in = 1'b0;
        tick(2);
        n_chk++; if (Estados !== 2'b11) begin n_fail++; $display("FAIL fault_clear_early: got %b expected 11", Estados); end
        tick(1);
        n_chk++; if (Estados !== 2'b00 || alarma !== 1'b0 || cambio !== 1'b1) begin n_fail++; $display("FAIL fault_exit: got %b/%b/%b expected 00/0/1", Estados, alarma, cambio); end
        ack = 1'b0;
        tick(1);
        n_chk++; if (Estados !== 2'b00 || cambio !== 1'b0) begin n_fail++; $display("FAIL fault_idle: got %b/%b expected 00/0", Estados, cambio); end
    endtask

    // Asynchronous reset in ACTIVE clears outputs immediately, without a clock edge.
    task automatic test_async_reset();
        sensor = 1'b1;
        tick(7);
        n_chk++; if (Estados !== 2'b10 || actuador !== 1'b1) begin n_fail++; $display("FAIL areset_pre: got %b/%b expected 10/1", Estados, actuador); end
        #2;
        reset_n = 1'b0;
        sensor  = 1'b0;
        #1;
        n_chk++; if (Estados !== 2'b00 || actuador !== 1'b0 || cambio !== 1'b0) begin n_fail++; $display("FAIL areset_now: got %b/%b/%b expected 00/0/0", Estados, actuador, cambio); end
        #2;
        reset_n = 1'b1;
        tick(5);
        n_chk++; if (Estados !== 2'b00 || cambio !== 1'b0) begin n_fail++; $display("FAIL areset_hold: got %b/%b expected 00/0", Estados, cambio); end
        sensor = 1'b1;
        tick(3);
        n_chk++; if (Estados !== 2'b01) begin n_fail++; $display("FAIL areset_restart: got %b expected 01", Estados); end
        sensor = 1'b0;
        tick(4);
    endtask

`ifdef DEBOUNCE_EN
    // Short glitch filtered; a held sensor reaches ALERT 3+DEB_CYCLES clocks after the edge.
    task automatic test_debounce();
        logic moved;
        moved = 1'b0;
        sensor = 1'b1;
        tick(3);
        sensor = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (Estados !== 2'b00) moved = 1'b1;
        end
        n_chk++; if (moved !== 1'b0) begin n_fail++; $display("FAIL deb_glitch: state moved=%b expected 0", moved); end
        sensor = 1'b1;
        tick(3 + c_DEB - 1);
        n_chk++; if (Estados !== 2'b00) begin n_fail++; $display("FAIL deb_early: got %b expected 00", Estados); end
        tick(1);
        n_chk++; if (Estados !== 2'b01 || cambio !== 1'b1) begin n_fail++; $display("FAIL deb_alert: got %b/%b expected 01/1", Estados, cambio); end
        sensor = 1'b0;
        tick(20);
    endtask
`endif

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
`ifdef DEBOUNCE_EN
        test_debounce();
`else
        test_alert_active();
        test_min_on();
        test_abort();
        test_fault();
        test_async_reset();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_control_estados
`default_nettype wire
